// File: rtl/ins_analyser_pkg.sv
// Shared MIPS-style encoding constants and the instruction-class enum used by
// the segment decoders.
package ins_analyser_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [31:0] NOP_BUBBLE = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_ZERO   = 32'h0000_0000;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_ALUR,
    CLS_ALUIMM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_NOP,
    CLS_ILLEGAL
  } ins_class_e;

endpackage

// File: rtl/ins_analyser_if.sv
// Instruction word in, class flags out, between segment control and decoder.
interface ins_analyser_if;
  import ins_analyser_pkg::*;

  logic        en;
  logic [31:0] IR;
  logic        isLoad;
  logic        isStore;
  logic        isALUR;
  logic        isALUImm;
  logic        isBranch;
  logic        isJump;
  logic        isNop;
  logic        isIllegal;
  logic        illegal_seen;

  modport master (
    output en, IR,
    input  isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop,
           isIllegal, illegal_seen
  );

  modport slave (
    input  en, IR,
    output isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop,
           isIllegal, illegal_seen
  );

endinterface

// File: rtl/ins_analyser.sv
// Combinational instruction-class decoder with a sticky illegal-instruction
// flag for the core's error path.
module ins_analyser
  import ins_analyser_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ins_analyser_if.slave bus
);

  logic [5:0] opcode;
  logic [5:0] funct;
  ins_class_e cls;
  logic       illegal_seen;

  assign opcode = bus.IR[31:26];
  assign funct  = bus.IR[5:0];

  // Decoding into a single enum keeps the flags one-hot by construction.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (bus.IR == NOP_BUBBLE || bus.IR == NOP_ZERO) begin
      cls = CLS_NOP;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = CLS_ALUR;
            FN_JR:                           cls = CLS_JUMP;
            default:                         cls = CLS_ILLEGAL;
          endcase
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI:   cls = CLS_ALUIMM;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls = CLS_LOAD;
        OP_SB, OP_SH, OP_SW:                cls = CLS_STORE;
        OP_BEQ, OP_BNE:                     cls = CLS_BRANCH;
        OP_J, OP_JAL:                       cls = CLS_JUMP;
        default:                            cls = CLS_ILLEGAL;
      endcase
    end
  end

  assign bus.isLoad    = (cls == CLS_LOAD);
  assign bus.isStore   = (cls == CLS_STORE);
  assign bus.isALUR    = (cls == CLS_ALUR);
  assign bus.isALUImm  = (cls == CLS_ALUIMM);
  assign bus.isBranch  = (cls == CLS_BRANCH);
  assign bus.isJump    = (cls == CLS_JUMP);
  assign bus.isNop     = (cls == CLS_NOP);
  assign bus.isIllegal = (cls == CLS_ILLEGAL);

  // Sticky error flag: only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (bus.en && cls == CLS_ILLEGAL) begin
      illegal_seen <= 1'b1;
    end
  end

  assign bus.illegal_seen = illegal_seen;

endmodule

// File: tb/tb_ins_analyser.sv
// Scoreboard bench for ins_analyser: directed encodings, sticky flag and
// asynchronous reset behaviour, plus a random one-hot sweep.
module tb_ins_analyser;

  // Flag order: {isLoad,isStore,isALUR,isALUImm,isBranch,isJump,isNop,isIllegal}
  localparam logic [7:0] C_LOAD = 8'h80;
  localparam logic [7:0] C_STOR = 8'h40;
  localparam logic [7:0] C_ALUR = 8'h20;
  localparam logic [7:0] C_IMM  = 8'h10;
  localparam logic [7:0] C_BR   = 8'h08;
  localparam logic [7:0] C_JMP  = 8'h04;
  localparam logic [7:0] C_NOP  = 8'h02;
  localparam logic [7:0] C_ILL  = 8'h01;

  typedef struct {
    logic [7:0]  cls;
    logic        sticky;
    logic        onehot_only;
    logic [31:0] ir;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  ins_analyser_if bus ();

  ins_analyser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] ir, input logic e, input logic [7:0] c,
                       input logic s, input logic oh, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    bus.IR = ir;
    bus.en = e;
    x.cls = c; x.sticky = s; x.onehot_only = oh; x.ir = ir; x.name = nm;
    sb_q.push_back(x);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        act = {bus.isLoad, bus.isStore, bus.isALUR, bus.isALUImm,
               bus.isBranch, bus.isJump, bus.isNop, bus.isIllegal};
        checks++;
        if (x.onehot_only) begin
          if ($countones(act) != 1) begin
            failures++;
            $display("FAIL %s IR=%h flags=%b required exactly one set", x.name, x.ir, act);
          end
        end else if (act !== x.cls) begin
          failures++;
          $display("FAIL %s IR=%h flags=%b required %b", x.name, x.ir, act, x.cls);
        end
        checks++;
        if (bus.illegal_seen !== x.sticky) begin
          failures++;
          $display("FAIL %s_sticky IR=%h illegal_seen=%b required %b",
                   x.name, x.ir, bus.illegal_seen, x.sticky);
        end
      end
    end
  end

  initial begin
    bus.IR = 32'h0;
    bus.en = 1'b0;

    apply(32'hFFFF_FFFF, 1'b0, C_NOP, 1'b0, 1'b0, "reset_bubble");
    @(posedge clk);
    #2 rst = 1'b0;

    apply(32'hFFFF_FFFF, 1'b0, C_NOP,  1'b0, 1'b0, "nop_bubble");
    apply(32'h0000_0000, 1'b0, C_NOP,  1'b0, 1'b0, "nop_zero");
    apply(32'h8C22_0004, 1'b0, C_LOAD, 1'b0, 1'b0, "lw");
    apply(32'h9422_0004, 1'b0, C_LOAD, 1'b0, 1'b0, "lhu");
    apply(32'hAC22_0004, 1'b0, C_STOR, 1'b0, 1'b0, "sw");
    apply(32'hA422_0004, 1'b0, C_STOR, 1'b0, 1'b0, "sh");
    apply(32'h2022_0005, 1'b0, C_IMM,  1'b0, 1'b0, "addi");
    apply(32'h3C01_1234, 1'b0, C_IMM,  1'b0, 1'b0, "lui");
    apply(32'h2C22_0001, 1'b0, C_IMM,  1'b0, 1'b0, "sltiu");
    apply(32'h0022_1820, 1'b0, C_ALUR, 1'b0, 1'b0, "add");
    apply(32'h0022_182B, 1'b0, C_ALUR, 1'b0, 1'b0, "sltu");
    apply(32'h0000_1940, 1'b0, C_ALUR, 1'b0, 1'b0, "sll_shamt");
    apply(32'h03E0_0008, 1'b0, C_JMP,  1'b0, 1'b0, "jr");
    apply(32'h1022_0003, 1'b0, C_BR,   1'b0, 1'b0, "beq");
    apply(32'h1422_0003, 1'b0, C_BR,   1'b0, 1'b0, "bne");
    apply(32'h0800_0010, 1'b0, C_JMP,  1'b0, 1'b0, "j");
    apply(32'h0C00_0010, 1'b0, C_JMP,  1'b0, 1'b0, "jal");
    apply(32'h0000_0009, 1'b0, C_ILL,  1'b0, 1'b0, "jalr_funct");
    apply(32'h0400_0000, 1'b0, C_ILL,  1'b0, 1'b0, "regimm_op");
    apply(32'hFFFF_FFFE, 1'b0, C_ILL,  1'b0, 1'b0, "near_bubble");
    apply(32'h0022_183F, 1'b0, C_ILL,  1'b0, 1'b0, "bad_funct");
    apply(32'hFC00_0000, 1'b0, C_ILL,  1'b0, 1'b0, "op3f");
    // The edge above saw an illegal word with en=0: flag must stay clear.
    apply(32'h0022_1820, 1'b0, C_ALUR, 1'b0, 1'b0, "en0_hold");
    apply(32'hFC00_0000, 1'b1, C_ILL,  1'b0, 1'b0, "en1_pre_edge");
    apply(32'h8C22_0004, 1'b0, C_LOAD, 1'b1, 1'b0, "sticky_set");
    apply(32'h0022_1820, 1'b0, C_ALUR, 1'b1, 1'b0, "sticky_hold");

    // Asynchronous clear mid-cycle, no clock edge before the sample.
    @(posedge clk);
    #1;
    bus.IR = 32'h0022_1820;
    bus.en = 1'b1;
    #1 rst = 1'b1;
    begin
      exp_t x;
      x.cls = C_ALUR; x.sticky = 1'b0; x.onehot_only = 1'b0;
      x.ir = 32'h0022_1820; x.name = "rst_async";
      sb_q.push_back(x);
    end

    // Reset held across an edge with an illegal word and en=1: reset wins.
    apply(32'hFC00_0000, 1'b1, C_ILL, 1'b0, 1'b0, "rst_override_a");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.IR = 32'h0022_1820;
    begin
      exp_t x;
      x.cls = C_ALUR; x.sticky = 1'b0; x.onehot_only = 1'b0;
      x.ir = 32'h0022_1820; x.name = "rst_override_b";
      sb_q.push_back(x);
    end

    for (int i = 0; i < 150; i++) begin
      apply($urandom, 1'b0, 8'h00, 1'b0, 1'b1, "onehot_sweep");
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
